// File: rtl/branch_pkg.sv
// branch_pkg: opcode and FSM state encodings shared by branch_ctrl and its return stack
package branch_pkg;
    localparam int ADDR_W = 8;
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_JZ   = 4'd2,
        OP_JNZ  = 4'd3,
        OP_JN   = 4'd4,
        OP_CALL = 4'd5,
        OP_RET  = 4'd6
    } op_e;
    typedef enum logic {RUN, KILL} state_e;
endpackage

// File: rtl/branch_ctrl_return_stack.sv
// return_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign top   = mem[ptr - AW'(1)];
    // ptr is the next free slot; when full it is also the oldest entry, so wrapping overwrites it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + AW'(1);
            cnt <= full ? cnt : cnt + CW'(1);
        end else if (pop) begin
            ptr <= ptr - AW'(1);
            cnt <= cnt - CW'(1);
        end
    end
    // entry storage needs no reset: the occupancy count defines which entries are live
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= din;
    end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branches into a registered PC redirect and kills wrong-path slots (BRANCH_CTRL_RAS_EN adds CALL/RET stack)
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int KILL_CYCLES = 2,
    parameter int RAS_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instrValid,
    input  logic [3:0]        instrOp,
    input  logic [ADDR_W-1:0] instrTarget,
    input  logic [ADDR_W-1:0] instructionPointer,
    input  logic              aluZero,
    input  logic              aluNeg,
    input  logic              flagsWe,
    output logic [ADDR_W-1:0] branchTarget,
    output logic              branchEnable,
    output logic              flush,
    output logic              rasOverflow,
    output logic              rasUnderflow
);
    localparam int CW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;
    state_e            state;
    logic [CW-1:0]     cnt;
    logic              z, n;
    op_e               op;
    logic              accept, taken, ras_ok;
    logic [ADDR_W-1:0] ret_addr, target;
    assign op     = op_e'(instrOp);
    assign accept = instrValid && state == RUN;
    assign taken  = accept && (op == OP_JMP || op == OP_CALL || (op == OP_JZ && z) ||
                    (op == OP_JNZ && !z) || (op == OP_JN && n) || (op == OP_RET && ras_ok));
    assign target = (op == OP_RET) ? ret_addr : instrTarget;
`ifdef BRANCH_CTRL_RAS_EN
    logic              ras_full, ras_empty;
    logic [ADDR_W-1:0] ras_top;
    return_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && op == OP_CALL),
        .pop   (accept && op == OP_RET && !ras_empty),
        .din   (instructionPointer + ADDR_W'(1)),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );
    assign ras_ok   = !ras_empty;
    assign ret_addr = ras_top;
    // sticky stack-misuse indicators, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rasOverflow  <= 1'b0;
            rasUnderflow <= 1'b0;
        end else begin
            if (accept && op == OP_CALL && ras_full) rasOverflow <= 1'b1;
            if (accept && op == OP_RET && ras_empty) rasUnderflow <= 1'b1;
        end
    end
`else
    logic unused_ras;
    assign unused_ras   = ^instructionPointer ^ (RAS_DEPTH > 0);
    assign ras_ok       = 1'b0;
    assign ret_addr     = '0;
    assign rasOverflow  = 1'b0;
    assign rasUnderflow = 1'b0;
`endif
    // flags, RUN/KILL sequencing and the registered redirect/flush outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            cnt          <= '0;
            z            <= 1'b0;
            n            <= 1'b0;
            branchTarget <= '0;
            branchEnable <= 1'b0;
            flush        <= 1'b0;
        end else begin
            branchEnable <= 1'b0;
            if (state == RUN) begin
                if (accept && flagsWe) begin
                    z <= aluZero;
                    n <= aluNeg;
                end
                if (taken) begin
                    state        <= KILL;
                    cnt          <= CW'(KILL_CYCLES - 1);
                    branchTarget <= target;
                    branchEnable <= 1'b1;
                    flush        <= 1'b1;
                end
            end else if (cnt == '0) begin
                state <= RUN;
                flush <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vector table, CALL/RET and reset sequences, and random traffic against a reference model
module tb_branch_ctrl;
    localparam int KC = 2;
    localparam int RD = 4;
`ifdef BRANCH_CTRL_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       instrValid = 1'b0, aluZero = 1'b0, aluNeg = 1'b0, flagsWe = 1'b0;
    logic [3:0] instrOp = 4'd0;
    logic [7:0] instrTarget = 8'd0, instructionPointer = 8'd0;
    logic [7:0] branchTarget;
    logic       branchEnable, flush, rasOverflow, rasUnderflow;
    int checks = 0, errors = 0;

    branch_ctrl #(.KILL_CYCLES(KC), .RAS_DEPTH(RD)) dut (
        .clk(clk), .rst(rst_n), .instrValid(instrValid), .instrOp(instrOp),
        .instrTarget(instrTarget), .instructionPointer(instructionPointer),
        .aluZero(aluZero), .aluNeg(aluNeg), .flagsWe(flagsWe),
        .branchTarget(branchTarget), .branchEnable(branchEnable), .flush(flush),
        .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
    );

    always #5 clk = ~clk;

    // reference model: flags, a queue as the stack, and a count of blocked cycles left
    logic       mz, mn, e_en, e_fl, e_ov, e_un;
    logic [7:0] e_tgt;
    logic [7:0] q[$];
    int         rem;

    task automatic model_reset();
        mz = 0; mn = 0; e_en = 0; e_fl = 0; e_ov = 0; e_un = 0; e_tgt = 8'h00; rem = 0;
        q.delete();
    endtask

    task automatic model_step(input logic v, input logic [3:0] op, input logic [7:0] t, ip,
                              input logic az, an, we);
        logic take;
        logic [7:0] dst;
        e_en = 0;
        if (rem > 0) begin
            rem--;
            e_fl = rem > 0;
        end else begin
            e_fl = 0;
            take = 0;
            dst = t;
            if (v) begin
                case (op)
                    4'd1: take = 1;
                    4'd2: take = mz;
                    4'd3: take = !mz;
                    4'd4: take = mn;
                    4'd5: begin
                        take = 1;
                        if (RAS) begin
                            if (q.size() == RD) begin
                                void'(q.pop_front());
                                e_ov = 1;
                            end
                            q.push_back(8'(ip + 8'd1));
                        end
                    end
                    4'd6: if (RAS) begin
                        if (q.size() == 0) e_un = 1;
                        else begin
                            take = 1;
                            dst = q.pop_back();
                        end
                    end
                    default: ;
                endcase
                if (we) begin
                    mz = az;
                    mn = an;
                end
                if (take) begin
                    e_en = 1;
                    e_fl = 1;
                    e_tgt = dst;
                    rem = KC;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("branchEnable", {7'd0, branchEnable}, {7'd0, e_en});
        chk("flush", {7'd0, flush}, {7'd0, e_fl});
        chk("branchTarget", branchTarget, e_tgt);
        chk("rasOverflow", {7'd0, rasOverflow}, {7'd0, e_ov});
        chk("rasUnderflow", {7'd0, rasUnderflow}, {7'd0, e_un});
    endtask

    task automatic cycle(input logic v, input logic [3:0] op, input logic [7:0] t, ip,
                         input logic az, an, we);
        instrValid = v; instrOp = op; instrTarget = t; instructionPointer = ip;
        aluZero = az; aluNeg = an; flagsWe = we;
        @(posedge clk);
        model_step(v, op, t, ip, az, an, we);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_en", {7'd0, branchEnable}, 8'd0);
        chk("rst_flush", {7'd0, flush}, 8'd0);
        chk("rst_target", branchTarget, 8'h00);
        chk("rst_ov_un", {6'd0, rasOverflow, rasUnderflow}, 8'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic gap();
        repeat (KC) cycle(1, 4'd0, 8'h00, 8'h00, 0, 0, 0);
    endtask

    typedef struct {
        logic v; logic [3:0] op; logic [7:0] t; logic az, an, we;
        logic en, fl; logic [7:0] et;
    } vec_t;

    function automatic vec_t mk(logic v, logic [3:0] op, logic [7:0] t, logic az, an, we,
                                logic en, fl, logic [7:0] et);
        vec_t r;
        r.v = v; r.op = op; r.t = t; r.az = az; r.an = an; r.we = we;
        r.en = en; r.fl = fl; r.et = et;
        return r;
    endfunction

    vec_t tbl[16];

    initial begin
        tbl[0]  = mk(1, 4'd1, 8'h40, 0, 0, 0, 1, 1, 8'h40);
        tbl[1]  = mk(1, 4'd0, 8'h00, 0, 0, 0, 0, 1, 8'h40);
        tbl[2]  = mk(1, 4'd0, 8'h00, 0, 0, 0, 0, 0, 8'h40);
        tbl[3]  = mk(1, 4'd2, 8'h10, 1, 0, 1, 0, 0, 8'h40);
        tbl[4]  = mk(1, 4'd2, 8'h10, 0, 0, 0, 1, 1, 8'h10);
        tbl[5]  = mk(1, 4'd1, 8'h77, 0, 1, 1, 0, 1, 8'h10);
        tbl[6]  = mk(1, 4'd0, 8'h00, 0, 0, 0, 0, 0, 8'h10);
        tbl[7]  = mk(1, 4'd3, 8'h22, 0, 0, 0, 0, 0, 8'h10);
        tbl[8]  = mk(1, 4'd4, 8'h33, 0, 0, 0, 0, 0, 8'h10);
        tbl[9]  = mk(1, 4'd2, 8'h55, 0, 0, 0, 1, 1, 8'h55);
        tbl[10] = mk(1, 4'd0, 8'h00, 0, 0, 0, 0, 1, 8'h55);
        tbl[11] = mk(1, 4'd0, 8'h00, 0, 0, 0, 0, 0, 8'h55);
        tbl[12] = mk(1, 4'd9, 8'h99, 0, 0, 0, 0, 0, 8'h55);
        tbl[13] = mk(0, 4'd1, 8'hAA, 0, 0, 0, 0, 0, 8'h55);
        tbl[14] = mk(1, 4'd3, 8'h66, 0, 0, 1, 0, 0, 8'h55);
        tbl[15] = mk(1, 4'd3, 8'h66, 0, 0, 0, 1, 1, 8'h66);

        model_reset();
        #2;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].op, tbl[i].t, 8'h00, tbl[i].az, tbl[i].an, tbl[i].we);
            chk("tbl_en", {7'd0, branchEnable}, {7'd0, tbl[i].en});
            chk("tbl_flush", {7'd0, flush}, {7'd0, tbl[i].fl});
            chk("tbl_target", branchTarget, tbl[i].et);
        end
        gap();

        // CALL at the top of the address space, then RET
        do_reset();
        cycle(1, 4'd5, 8'h20, 8'hFF, 0, 0, 0);
        gap();
        cycle(1, 4'd6, 8'h00, 8'h00, 0, 0, 0);
        gap();

        // five CALLs into a four-deep stack, then five RETs
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4'd5, 8'h80 + 8'(i), 8'h10 + 8'(i), 0, 0, 0);
            gap();
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4'd6, 8'h00, 8'h00, 0, 0, 0);
            gap();
        end

        // reset mid-kill clears outputs immediately and the flags
        do_reset();
        cycle(1, 4'd0, 8'h00, 8'h00, 0, 1, 1);
        cycle(1, 4'd1, 8'hC0, 8'h00, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("midkill_flush", {7'd0, flush}, 8'd0);
        chk("midkill_en", {7'd0, branchEnable}, 8'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        cycle(1, 4'd4, 8'h44, 8'h00, 0, 0, 0);
        chk("jn_after_rst", {7'd0, branchEnable}, 8'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            cycle($urandom_range(0, 4) != 0, op, 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
